// File: rtl/neo_shift_seq.sv
// neo_shift_seq: lite-address shifter with a self-advancing shift offset.
//
// The block sits between the frame-data decoder and the neo_color addressing
// path. On every frame_start it remaps the lite address in frame_data to
// (addr + offset) mod lite-count. The offset can hold, rotate up, rotate down
// or ping-pong, stepping once every sft_rate+1 step ticks, so patterns animate
// without the host rewriting the shift value.
//
// Parameters:
//   DW   - width of frame_data
//   AW   - lite-address width (lite count up to 2^AW)
//   ALSB - LSB of the address field inside frame_data
//   OW   - width of neo_addr (address is zero-extended, AW <= OW)
//   RW   - width of the step-rate divider
//
// Ports:
//   clk8          - system clock, all flops on its rising edge
//   reset8        - asynchronous active-high reset
//   frame_start_i - one-cycle strobe, frame_data_i valid
//   frame_data_i  - frame word carrying the lite address
//   step_tick_i   - one-cycle strobe, advances the step divider
//   sft_load_i    - one-cycle strobe, loads sft_init_i into the offset
//   sft_init_i    - initial offset
//   sft_max_i     - lite count (modulus), 0 disables remapping
//   sft_mode_i    - 0 static, 1 rotate up, 2 rotate down, 3 ping-pong
//   sft_rate_i    - offset steps once per sft_rate_i+1 step ticks
//   neo_addr_o    - remapped lite address, holds between strobes
//   addr_vld_o    - one-cycle strobe, neo_addr_o updated
//   sft_pos_o     - current offset
//   sft_dir_o     - ping-pong direction (0 up, 1 down)
//   sft_wrap_o    - one-cycle pulse when the offset wraps or reverses

module neo_shift_seq #(
  parameter int unsigned DW   = 26,
  parameter int unsigned AW   = 6,
  parameter int unsigned ALSB = 20,
  parameter int unsigned OW   = 8,
  parameter int unsigned RW   = 8
) (
  input  logic          clk8,
  input  logic          reset8,
  input  logic          frame_start_i,
  input  logic [DW-1:0] frame_data_i,
  input  logic          step_tick_i,
  input  logic          sft_load_i,
  input  logic [AW-1:0] sft_init_i,
  input  logic [AW:0]   sft_max_i,
  input  logic [1:0]    sft_mode_i,
  input  logic [RW-1:0] sft_rate_i,
  output logic [OW-1:0] neo_addr_o,
  output logic          addr_vld_o,
  output logic [AW-1:0] sft_pos_o,
  output logic          sft_dir_o,
  output logic          sft_wrap_o
);

  // Ping-pong direction states, stored directly as sft_dir.
  localparam logic [0:0] StUp   = 1'b0;
  localparam logic [0:0] StDown = 1'b1;

  localparam logic [1:0] ModeStatic = 2'd0;
  localparam logic [1:0] ModeUp     = 2'd1;
  localparam logic [1:0] ModeDown   = 2'd2;
  localparam logic [1:0] ModePing   = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [OW-1:0] neo_addr_q, neo_addr_d;
  logic          addr_vld_q;
  logic [AW-1:0] pos_q, pos_d;
  logic [0:0]    dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic [RW-1:0] div_q, div_d;

  // ---------------------------------------------------------------------------
  // Shared modulus helpers
  // ---------------------------------------------------------------------------
  logic [AW:0]   max_m1;
  logic [AW:0]   max_m2;
  logic [AW-1:0] last_pos;
  logic [AW-1:0] prev_last_pos;
  logic [AW:0]   pos_ext;
  logic          max_small;
  logic          pos_over;

  // sft_max_i <= 2^AW, so m-1 and m-2 always fit in AW bits when used.
  assign max_m1        = sft_max_i - (AW+1)'(1);
  assign max_m2        = sft_max_i - (AW+1)'(2);
  assign last_pos      = max_m1[AW-1:0];
  assign prev_last_pos = max_m2[AW-1:0];
  assign pos_ext       = {1'b0, pos_q};
  assign max_small     = (sft_max_i <= (AW+1)'(1));
  assign pos_over      = (pos_ext >= sft_max_i);

  // ---------------------------------------------------------------------------
  // Address path
  // ---------------------------------------------------------------------------
  logic [AW-1:0] addr_field;
  logic [AW:0]   addr_ext;
  logic [AW:0]   addr_sum;
  logic [AW:0]   addr_remap;
  logic          addr_pass;

  assign addr_field = frame_data_i[ALSB +: AW];
  assign addr_ext   = {1'b0, addr_field};
  // Uses the registered offset, so a same-cycle step or load applies to the
  // following frame only.
  assign addr_sum   = addr_ext + pos_ext;
  assign addr_pass  = (sft_max_i == '0) || (addr_ext >= sft_max_i);

  always_comb begin
    addr_remap = addr_sum;
    if (addr_pass) begin
      addr_remap = addr_ext;
    end else if (addr_sum >= sft_max_i) begin
      addr_remap = addr_sum - sft_max_i;
    end
  end

  always_comb begin
    neo_addr_d = neo_addr_q;
    if (frame_start_i) begin
      neo_addr_d = OW'(addr_remap[AW-1:0]);
    end
  end

  // Only the address field is consumed from the frame word.
  logic unused_frame_bits;
  assign unused_frame_bits = ^frame_data_i;

  // ---------------------------------------------------------------------------
  // Step divider
  // ---------------------------------------------------------------------------
  logic step_now;

  assign step_now = step_tick_i && (div_q == sft_rate_i);

  always_comb begin
    div_d = div_q;
    if (sft_load_i) begin
      div_d = '0;
    end else if (step_tick_i) begin
      div_d = step_now ? '0 : div_q + RW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Offset sequencer
  // ---------------------------------------------------------------------------
  logic [AW-1:0] load_val;

  always_comb begin
    if (sft_max_i == '0) begin
      load_val = '0;
    end else if ({1'b0, sft_init_i} >= sft_max_i) begin
      load_val = last_pos;
    end else begin
      load_val = sft_init_i;
    end
  end

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (sft_load_i) begin
      pos_d = load_val;
      dir_d = StUp;
    end else if (max_small) begin
      // A one-lite (or empty) ring has a single legal offset.
      pos_d = '0;
    end else if (pos_over) begin
      // sft_max was lowered under the offset: pull it back into range first.
      pos_d = last_pos;
    end else if (step_now) begin
      unique case (sft_mode_i)
        ModeStatic: pos_d = pos_q;
        ModeUp: begin
          if (pos_q == last_pos) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + AW'(1);
          end
        end
        ModeDown: begin
          if (pos_q == '0) begin
            pos_d  = last_pos;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - AW'(1);
          end
        end
        ModePing: begin
          if (dir_q == StUp) begin
            if (pos_q == last_pos) begin
              dir_d  = StDown;
              pos_d  = prev_last_pos;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + AW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d  = StUp;
              pos_d  = AW'(1);
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - AW'(1);
            end
          end
        end
        default: pos_d = pos_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk8 or posedge reset8) begin
    if (reset8) begin
      neo_addr_q <= '0;
      addr_vld_q <= 1'b0;
      pos_q      <= '0;
      dir_q      <= StUp;
      wrap_q     <= 1'b0;
      div_q      <= '0;
    end else begin
      neo_addr_q <= neo_addr_d;
      addr_vld_q <= frame_start_i;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      div_q      <= div_d;
    end
  end

  assign neo_addr_o = neo_addr_q;
  assign addr_vld_o = addr_vld_q;
  assign sft_pos_o  = pos_q;
  assign sft_dir_o  = dir_q;
  assign sft_wrap_o = wrap_q;

endmodule

// File: tb/tb_neo_shift_seq.sv
// Self-checking bench for neo_shift_seq: address remap results go through a
// queue scoreboard, offset sequencing is checked per scenario task.

module tb_neo_shift_seq;

  localparam int DW   = 26;
  localparam int AW   = 6;
  localparam int ALSB = 20;
  localparam int OW   = 8;
  localparam int RW   = 8;

  logic          clk8 = 1'b0;
  logic          reset8 = 1'b1;
  logic          frame_start = 1'b0;
  logic [DW-1:0] frame_data = '0;
  logic          step_tick = 1'b0;
  logic          sft_load = 1'b0;
  logic [AW-1:0] sft_init = '0;
  logic [AW:0]   sft_max = '0;
  logic [1:0]    sft_mode = '0;
  logic [RW-1:0] sft_rate = '0;
  logic [OW-1:0] neo_addr;
  logic          addr_vld;
  logic [AW-1:0] sft_pos;
  logic          sft_dir;
  logic          sft_wrap;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  neo_shift_seq #(
    .DW  (DW),
    .AW  (AW),
    .ALSB(ALSB),
    .OW  (OW),
    .RW  (RW)
  ) dut (
    .clk8         (clk8),
    .reset8       (reset8),
    .frame_start_i(frame_start),
    .frame_data_i (frame_data),
    .step_tick_i  (step_tick),
    .sft_load_i   (sft_load),
    .sft_init_i   (sft_init),
    .sft_max_i    (sft_max),
    .sft_mode_i   (sft_mode),
    .sft_rate_i   (sft_rate),
    .neo_addr_o   (neo_addr),
    .addr_vld_o   (addr_vld),
    .sft_pos_o    (sft_pos),
    .sft_dir_o    (sft_dir),
    .sft_wrap_o   (sft_wrap)
  );

  always #5 clk8 = ~clk8;

  // Advance one clock and sample 1 time unit after the edge. Any frame pushed
  // before this edge must show up now (latency 1); otherwise addr_vld is 0.
  task automatic cycle();
    logic [OW-1:0] e;
    @(posedge clk8);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (addr_vld !== 1'b1) begin
        bad++;
        $display("FAIL addr_vld_missing: got %b want 1 (expected addr %0d)", addr_vld, e);
      end else if (neo_addr !== e) begin
        bad++;
        $display("FAIL neo_addr: got %0d want %0d", neo_addr, e);
      end
    end else if (addr_vld !== 1'b0) begin
      bad++;
      $display("FAIL addr_vld_spurious: got %b want 0", addr_vld);
    end
  endtask

  // Drive a frame carrying address a with random surrounding bits.
  task automatic drive_frame(input logic [AW-1:0] a, input logic [OW-1:0] e);
    logic [DW-1:0] d;
    d = DW'($urandom);
    d[ALSB +: AW] = a;
    frame_data  = d;
    frame_start = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [AW-1:0] a, input logic [OW-1:0] e);
    drive_frame(a, e);
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic do_load(input logic [AW-1:0] init);
    sft_init = init;
    sft_load = 1'b1;
    cycle();
    sft_load = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({neo_addr, addr_vld, sft_pos, sft_dir, sft_wrap} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%0d vld=%b pos=%0d dir=%b wrap=%b want all 0",
               neo_addr, addr_vld, sft_pos, sft_dir, sft_wrap);
    end
    // frame_start while in reset must not produce a strobe.
    frame_data  = '1;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    reset8  = 1'b0;
    sft_max = 7'd24;
    send_frame(6'd5, 8'd5);
    cycle();
  endtask

  task automatic test_load_wrap();
    sft_mode = 2'd0;
    do_load(6'd20);
    total++;
    if (sft_pos !== 6'd20) begin
      bad++;
      $display("FAIL load_pos: got %0d want 20", sft_pos);
    end
    send_frame(6'd3, 8'd23);
    send_frame(6'd4, 8'd0);
    send_frame(6'd30, 8'd30);
    // Out-of-range init clamps to m-1.
    do_load(6'd50);
    total++;
    if (sft_pos !== 6'd23) begin
      bad++;
      $display("FAIL load_clamp: got %0d want 23", sft_pos);
    end
  endtask

  task automatic test_rotate_up();
    int   ep[9] = '{2, 2, 3, 3, 3, 0, 0, 0, 1};
    logic ew[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    sft_mode = 2'd1;
    sft_rate = 8'd2;
    sft_max  = 7'd4;
    do_load(6'd2);
    for (int i = 0; i < 9; i++) begin
      step_tick = 1'b1;
      cycle();
      total++;
      if (sft_pos !== AW'(ep[i]) || sft_wrap !== ew[i]) begin
        bad++;
        $display("FAIL rotate_up tick %0d: got pos=%0d wrap=%b want pos=%0d wrap=%b",
                 i + 1, sft_pos, sft_wrap, ep[i], ew[i]);
      end
    end
    step_tick = 1'b0;
    cycle();
  endtask

  task automatic test_rotate_down();
    int   ep[3] = '{0, 4, 3};
    logic ew[3] = '{0, 1, 0};
    sft_mode = 2'd2;
    sft_rate = 8'd0;
    sft_max  = 7'd5;
    do_load(6'd1);
    for (int i = 0; i < 3; i++) begin
      step_tick = 1'b1;
      cycle();
      total++;
      if (sft_pos !== AW'(ep[i]) || sft_wrap !== ew[i]) begin
        bad++;
        $display("FAIL rotate_down tick %0d: got pos=%0d wrap=%b want pos=%0d wrap=%b",
                 i + 1, sft_pos, sft_wrap, ep[i], ew[i]);
      end
    end
    step_tick = 1'b0;
    cycle();
  endtask

  task automatic test_pingpong();
    int   ep[6] = '{1, 2, 1, 0, 1, 2};
    logic ew[6] = '{0, 0, 1, 0, 1, 0};
    logic ed[6] = '{0, 0, 1, 1, 0, 0};
    sft_mode = 2'd3;
    sft_rate = 8'd0;
    sft_max  = 7'd3;
    do_load(6'd0);
    for (int i = 0; i < 6; i++) begin
      step_tick = 1'b1;
      cycle();
      total++;
      if (sft_pos !== AW'(ep[i]) || sft_wrap !== ew[i] || sft_dir !== ed[i]) begin
        bad++;
        $display("FAIL pingpong tick %0d: got pos=%0d wrap=%b dir=%b want pos=%0d wrap=%b dir=%b",
                 i + 1, sft_pos, sft_wrap, sft_dir, ep[i], ew[i], ed[i]);
      end
    end
    step_tick = 1'b0;
    cycle();
  endtask

  task automatic test_same_cycle();
    sft_mode = 2'd1;
    sft_rate = 8'd1;
    sft_max  = 7'd24;
    do_load(6'd2);
    // One tick so the next tick is a dividing one.
    step_tick = 1'b1;
    cycle();
    // Load, dividing tick and frame together: frame uses old pos 2.
    sft_init = 6'd7;
    sft_load = 1'b1;
    drive_frame(6'd1, 8'd3);
    cycle();
    sft_load    = 1'b0;
    frame_start = 1'b0;
    total++;
    if (sft_pos !== 6'd7 || sft_wrap !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_load: got pos=%0d wrap=%b want pos=7 wrap=0", sft_pos, sft_wrap);
    end
    // Divider restarted at 0: first tick holds, second steps.
    cycle();
    total++;
    if (sft_pos !== 6'd7) begin
      bad++;
      $display("FAIL div_restart_hold: got pos=%0d want 7", sft_pos);
    end
    cycle();
    step_tick = 1'b0;
    total++;
    if (sft_pos !== 6'd8) begin
      bad++;
      $display("FAIL div_restart_step: got pos=%0d want 8", sft_pos);
    end
    send_frame(6'd20, 8'd4);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs[6] = '{6'd0, 6'd5, 6'd6, 6'd9, 6'd10, 6'd63};
    logic [OW-1:0] exps[6]  = '{8'd4, 8'd9, 8'd0, 8'd3, 8'd10, 8'd63};
    sft_mode = 2'd0;
    sft_max  = 7'd10;
    do_load(6'd4);
    for (int i = 0; i < 6; i++) begin
      drive_frame(addrs[i], exps[i]);
      cycle();
    end
    frame_start = 1'b0;
    cycle();
    // neo_addr holds its last value between strobes.
    total++;
    if (neo_addr !== 8'd63) begin
      bad++;
      $display("FAIL neo_addr_hold: got %0d want 63", neo_addr);
    end
  endtask

  task automatic test_clamp();
    sft_mode = 2'd0;
    sft_max  = 7'd24;
    do_load(6'd8);
    sft_max = 7'd5;
    cycle();
    total++;
    if (sft_pos !== 6'd4 || sft_wrap !== 1'b0) begin
      bad++;
      $display("FAIL clamp_max: got pos=%0d wrap=%b want pos=4 wrap=0", sft_pos, sft_wrap);
    end
  endtask

  task automatic test_reset_mid();
    sft_mode = 2'd3;
    sft_rate = 8'd0;
    sft_max  = 7'd8;
    do_load(6'd6);
    step_tick = 1'b1;
    cycle();
    cycle();
    cycle();
    total++;
    if (sft_pos !== 6'd5 || sft_dir !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state: got pos=%0d dir=%b want pos=5 dir=1", sft_pos, sft_dir);
    end
    // Mid-cycle reset with a frame and tick in flight.
    frame_data  = '0;
    frame_data[ALSB +: AW] = 6'd2;
    frame_start = 1'b1;
    sft_max     = '0;
    #2;
    reset8 = 1'b1;
    #1;
    total++;
    if ({neo_addr, addr_vld, sft_pos, sft_dir, sft_wrap} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got addr=%0d vld=%b pos=%0d dir=%b wrap=%b want all 0",
               neo_addr, addr_vld, sft_pos, sft_dir, sft_wrap);
    end
    frame_start = 1'b0;
    cycle();
    reset8 = 1'b0;
    // m == 0: pass-through addresses, offset pinned, no wrap.
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (sft_pos !== 6'd0 || sft_wrap !== 1'b0) begin
        bad++;
        $display("FAIL m0_step %0d: got pos=%0d wrap=%b want pos=0 wrap=0", i, sft_pos, sft_wrap);
      end
    end
    step_tick = 1'b0;
    send_frame(6'd5, 8'd5);
    send_frame(6'd40, 8'd40);
    cycle();
  endtask

  initial begin
    test_reset();
    test_load_wrap();
    test_rotate_up();
    test_rotate_down();
    test_pingpong();
    test_same_cycle();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neo_shift_seq.md
Name: neo_shift_seq

Overview:
- Parametrised lite-address shifter with a self-advancing shift offset.
- Sits between the frame-data decoder and the neo_color addressing path. On each frame_start it remaps the incoming lite address to (addr + offset) mod lite-count.
- The offset is static, rotates up or down, or ping-pongs, advancing once every N step ticks. Patterns animate without the host rewriting the shift value.

Parameters:
- DW, 26, width of frame_data.
- AW, 6, lite-address width; lite count up to 2^AW.
- ALSB, 20, LSB position of the address field in frame_data (field = frame_data[ALSB+AW-1:ALSB]).
- OW, 8, width of neo_addr; address zero-extended; AW <= OW required.
- RW, 8, width of the step-rate divider.

Ports:
- clk8, input, 1, system clock.
- reset8, input, 1, reset.
- frame_start, input, 1, one-cycle strobe; frame_data valid.
- frame_data, input, DW, frame word carrying the lite address.
- step_tick, input, 1, one-cycle strobe (typically end of refresh); advances the divider.
- sft_load, input, 1, one-cycle strobe; loads sft_init into the offset.
- sft_init, input, AW, initial offset.
- sft_max, input, AW+1, lite count (modulus).
- sft_mode, input, 2, 0 static, 1 rotate up, 2 rotate down, 3 ping-pong.
- sft_rate, input, RW, offset steps once per sft_rate+1 step_ticks.
- neo_addr, output, OW, remapped lite address.
- addr_vld, output, 1, one-cycle strobe; neo_addr updated.
- sft_pos, output, AW, current offset.
- sft_dir, output, 1, ping-pong direction (0 up, 1 down).
- sft_wrap, output, 1, one-cycle pulse when the offset wraps or reverses.

Behaviour:
- Reset:
  - reset8 is asynchronous, active-high; clock is clk8; all flops are on posedge clk8.
  - Reset values: neo_addr=0, addr_vld=0, sft_pos=0, sft_dir=0, sft_wrap=0, divider=0.
  - Reset asserted mid-frame aborts immediately; no partial update survives.
- Address path (latency 1):
  - On frame_start: a = address field; sum = a + sft_pos computed at AW+1 bits.
  - If sft_max==0 or a >= sft_max: neo_addr <= a (pass-through).
  - Else if sum >= sft_max: neo_addr <= sum - sft_max.
  - Else: neo_addr <= sum.
  - addr_vld = registered frame_start.
  - neo_addr holds between strobes.
- Divider:
  - On step_tick: if divider == sft_rate, divider <= 0 and the offset steps; else divider increments.
  - sft_rate=0 steps on every tick.
- Offset step by mode (m = sft_max):
  - Mode 0: offset holds; divider still runs.
  - Mode 1: pos==m-1 -> 0 with sft_wrap; else pos+1.
  - Mode 2: pos==0 -> m-1 with sft_wrap; else pos-1.
  - Mode 3 state machine UP/DOWN (sft_dir):
    - UP at pos==m-1: goes DOWN, pos <= m-2, sft_wrap.
    - DOWN at pos==0: goes UP, pos <= 1, sft_wrap.
    - Otherwise pos moves ±1 in the current direction.
  - m<=1: pos forced to 0, no wrap pulse, sft_dir unchanged.
- sft_load:
  - pos <= sft_init, or m-1 if sft_init >= m (0 if m==0).
  - divider <= 0, sft_dir <= 0.
  - Takes priority over a same-cycle step; no sft_wrap.
- sft_max lowered below the current pos: pos is clamped to m-1 on the next clock (0 if m==0).
- Simultaneous events: frame_start in the same cycle as a step or load uses the old pos; the new pos applies from the next frame_start.
- Mode change takes effect at the next step; a mode change does not reset sft_dir.
- sft_wrap is registered and asserts in the cycle after the step/ticking edge, for one cycle.

Test Plan:
- Reset, then frame_start with address 5, sft_max=24, pos 0 -> neo_addr=5 and addr_vld one cycle later; all outputs 0 during reset.
- Load sft_init=20, m=24; frame addresses 3 and 4 -> neo_addr 23, then 0 (wrap). Address 30 -> pass-through 30.
- Mode 1, sft_rate=2, m=4, init 2; 9 step_ticks -> pos 2,2,3,3,3,0(sft_wrap),0,0,1 (advancing on ticks 3, 6, 9).
- Mode 3, rate 0, m=3, init 0; 6 ticks -> pos 1,2,1(wrap, dir=1),0,1(wrap, dir=0),2.
- Same cycle sft_load (init 7) with a dividing step_tick and frame_start (addr 1, old pos 2, m=24) -> neo_addr=3, then pos=7, no wrap, divider 0.
- Assert reset8 mid-ping-pong (dir=1, pos=5), sft_max=0, edge cases -> outputs 0 immediately. After release with m=0: pass-through addresses, pos stays 0, no sft_wrap.
